// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// A shift-add multiply or restoring divide retires one bit per cycle. The
// pipeline is stalled until a one-cycle done pulse presents result/rd_addr_out.
module ex_muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            stall_out,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  localparam logic [XLEN-1:0]  SMIN     = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // Operand sign handling (evaluated in PREP from latched operands)
  logic            a_signed, b_signed, a_neg, b_neg, is_div, is_sdiv;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign a_signed    = (op_q == OP_MULH) | (op_q == OP_MULHSU) | (op_q == OP_DIV) | (op_q == OP_REM);
  assign b_signed    = (op_q == OP_MULH) | (op_q == OP_DIV) | (op_q == OP_REM);
  assign a_neg       = a_signed & a_q[XLEN-1];
  assign b_neg       = b_signed & b_q[XLEN-1];
  assign a_mag       = a_neg ? (-a_q) : a_q;
  assign b_mag       = b_neg ? (-b_q) : b_q;
  assign is_div      = op_q[2];
  assign is_sdiv     = (op_q == OP_DIV) | (op_q == OP_REM);
  assign div_by_zero = is_div & (b_q == '0);
  assign div_ovf     = is_sdiv & (a_q == SMIN) & (b_q == '1);
  assign special_res = div_by_zero ? (op_q[1] ? a_q : '1) : (op_q[1] ? '0 : SMIN);

  // One multiply step: conditional add into the upper half, then shift right
  logic [XLEN-1:0]   mul_add;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx;

  assign mul_add = acc_q[0] ? dvs_q : '0;
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_add};
  assign mul_nx  = {mul_sum, acc_q[XLEN-1:1]};

  // One restoring-divide step. The shifted remainder can reach XLEN+1 bits
  // when the divisor exceeds 2^(XLEN-1); the compare uses the full width,
  // while the kept difference always fits in XLEN bits.
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] div_nx;

  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_ge   = div_sh >= {1'b0, dvs_q};
  assign div_diff = div_sh[XLEN-1:0] - dvs_q;
  assign div_nx   = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};

  // Final sign fix-up and word selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res, div_raw, div_res, fix_res;

  assign prod_fix = neg_q ? (-acc_q) : acc_q;
  assign mul_res  = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign div_raw  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
  assign div_res  = neg_q ? (-div_raw) : div_raw;
  assign fix_res  = is_div ? div_res : mul_res;

  // Next-state and datapath update; flush overrides everything outside IDLE
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          rd_d    = rd_addr_in;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (div_by_zero || div_ovf) begin
          result_d = special_res;
          rd_out_d = rd_q;
          state_d  = S_DONE;
        end else begin
          acc_d   = {{XLEN{1'b0}}, a_mag};
          dvs_d   = b_mag;
          neg_d   = is_div ? (op_q[1] ? a_neg : (a_neg ^ b_neg)) : (a_neg ^ b_neg);
          cnt_d   = CNT_INIT;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = is_div ? div_nx : mul_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An abort discards any result being committed this cycle; in DONE the
    // result was already committed, so done still pulses.
    if (flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stall_out   = busy | (start & (state_q == S_IDLE));
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign rd_addr_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: directed and randomized M-extension
// ops checked against a plain-arithmetic reference model.
module tb_ex_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_addr_in;
  logic        busy, stall_out, done;
  logic [31:0] result;
  logic [4:0]  rd_addr_out;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_res;
  logic [4:0]  last_rd;

  always #5 clk = ~clk;

  ex_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .rd_addr_in (rd_addr_in),
    .flush      (flush),
    .busy       (busy),
    .stall_out  (stall_out),
    .done       (done),
    .result     (result),
    .rd_addr_out(rd_addr_out)
  );

  // Reference result computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint     sx, sy, sp, sq;
    logic [63:0] ux, uy, up;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (o)
      3'd0: begin sp = sx * sy; r = sp[31:0]; end
      3'd1: begin sp = sx * sy; r = sp[63:32]; end
      3'd2: begin sp = sx * longint'(uy); r = sp[63:32]; end
      3'd3: begin up = ux * uy; r = up[63:32]; end
      3'd4: begin
        if (y == 0) r = 32'hFFFF_FFFF;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin sq = sx / sy; r = sq[31:0]; end
      end
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) r = x;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
        else begin sq = sx % sy; r = sq[31:0]; end
      end
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 0) || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'd0;
      1: v = 32'd1;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'h8000_0000;
      4: v = $urandom_range(0, 100);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issue one op with start held until done. flush_at >= 1 asserts flush for
  // that cycle; b2b=1 returns right after done so the next op starts in the
  // following cycle.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] exp_r, input int flush_at, input bit b2b);
    int   lat;
    bit   aborted, finished;
    logic exp_busy;
    lat      = is_special(o, x, y) ? 2 : 35;
    aborted  = (flush_at >= 1) && (flush_at < lat);
    finished = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y; rd_addr_in = r;
    for (int cyc = 0; cyc <= 60 && !finished; cyc++) begin
      @(negedge clk);
      if (aborted && cyc == flush_at + 1) begin
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_res || rd_addr_out !== last_rd) begin
          n_fail++;
          $display("FAIL flush_abort op%0d cyc%0d: busy=%b done=%b result=%h rd=%0d, expected busy=0 done=0 result=%h rd=%0d",
                   o, cyc, busy, done, result, rd_addr_out, last_res, last_rd);
        end
        finished = 1'b1;
      end else begin
        exp_busy = (cyc >= 1);
        n_cmp++;
        if (busy !== exp_busy) begin
          n_fail++;
          $display("FAIL busy op%0d cyc%0d: got %b expected %b", o, cyc, busy, exp_busy);
        end
        n_cmp++;
        if (stall_out !== 1'b1) begin
          n_fail++;
          $display("FAIL stall op%0d cyc%0d: got %b expected 1", o, cyc, stall_out);
        end
        if (cyc == lat) begin
          n_cmp++;
          if (done !== 1'b1 || result !== exp_r || rd_addr_out !== r) begin
            n_fail++;
            $display("FAIL result op%0d a=%h b=%h cyc%0d: done=%b result=%h rd=%0d, expected done=1 result=%h rd=%0d",
                     o, x, y, cyc, done, result, rd_addr_out, exp_r, r);
          end
          last_res = exp_r;
          last_rd  = r;
          start    = 1'b0;
          flush    = 1'b0;
          finished = 1'b1;
        end else begin
          n_cmp++;
          if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_early op%0d cyc%0d: got %b expected 0", o, cyc, done);
          end
        end
      end
      if (!finished) begin
        if (cyc == 60) begin
          n_cmp++;
          n_fail++;
          $display("FAIL timeout op%0d: no completion within 60 cycles, expected at %0d", o, lat);
          start = 1'b0;
          flush = 1'b0;
        end else begin
          @(posedge clk); #1;
          if (cyc + 1 == flush_at) flush = 1'b1;
          if (aborted && cyc + 1 == flush_at + 1) begin
            flush = 1'b0;
            start = 1'b0;
          end
        end
      end
    end
    if (!b2b) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || stall_out !== 1'b0 || result !== last_res) begin
        n_fail++;
        $display("FAIL idle_after op%0d: busy=%b done=%b stall=%b result=%h, expected 0 0 0 %h",
                 o, busy, done, stall_out, result, last_res);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0; rd_addr_in = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_out !== 1'b0 || result !== 32'd0 || rd_addr_out !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b result=%h rd=%0d, expected all zero",
               busy, done, stall_out, result, rd_addr_out);
    end
    rst      = 1'b1;
    last_res = 32'd0;
    last_rd  = 5'd0;
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [12] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] t_a  [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC, 32'hFFFF_FFEC,
                               32'd20, 32'd20, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] t_b  [12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd3, 32'd3,
                               32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_e  [12] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFE,
                               32'd6, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    for (int i = 0; i < 12; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 5'(i + 1), t_e[i], -1, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_op(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, ref_res(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), -1, 1'b1);
    do_op(3'd5, 32'd1000, 32'd7, 5'd21, 32'd142, -1, 1'b1);
    do_op(3'd7, 32'd1000, 32'd0, 5'd22, 32'd1000, -1, 1'b0);
  endtask

  task automatic test_flush_idle();
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; rd_addr_in = 5'd30;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || result !== last_res || rd_addr_out !== last_rd) begin
      n_fail++;
      $display("FAIL flush_idle: busy=%b result=%h rd=%0d, expected busy=0 result=%h rd=%0d",
               busy, result, rd_addr_out, last_res, last_rd);
    end
  endtask

  task automatic test_flush_done();
    do_op(3'd0, 32'd9, 32'd9, 5'd23, 32'd81, 35, 1'b0);
    do_op(3'd4, 32'd9, 32'd0, 5'd24, 32'hFFFF_FFFF, 2, 1'b0);
    do_op(3'd4, 32'd9, 32'd0, 5'd25, 32'hFFFF_FFFF, 1, 1'b0);
  endtask

  task automatic test_flush_restart();
    logic [31:0] exp2;
    bit          seen;
    exp2 = ref_res(3'd0, 32'd1234, 32'd5678);
    seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'd77; b = 32'd88; rd_addr_in = 5'd13;
    for (int cyc = 0; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      if (cyc == 11) begin
        n_cmp++;
        if (busy !== 1'b0 || result !== last_res || rd_addr_out !== last_rd) begin
          n_fail++;
          $display("FAIL flush_mid: busy=%b result=%h rd=%0d, expected busy=0 result=%h rd=%0d",
                   busy, result, rd_addr_out, last_res, last_rd);
        end
      end
      if (cyc == 46) begin
        n_cmp++;
        if (done !== 1'b1 || result !== exp2 || rd_addr_out !== 5'd14) begin
          n_fail++;
          $display("FAIL restart_result: done=%b result=%h rd=%0d, expected done=1 result=%h rd=14",
                   done, result, rd_addr_out, exp2);
        end
        last_res = exp2;
        last_rd  = 5'd14;
        start    = 1'b0;
        seen     = 1'b1;
      end else begin
        n_cmp++;
        if (done !== 1'b0) begin
          n_fail++;
          $display("FAIL restart_early_done cyc%0d: got %b expected 0", cyc, done);
        end
      end
      if (!seen) begin
        @(posedge clk); #1;
        if (cyc + 1 == 10) flush = 1'b1;
        if (cyc + 1 == 11) begin
          flush = 1'b0; a = 32'd1234; b = 32'd5678; rd_addr_in = 5'd14;
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL restart_timeout: no done, expected at cycle 46");
      start = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, -1, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7; rd_addr_in = 5'd17;
    repeat (20) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || rd_addr_out !== 5'd0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b result=%h rd=%0d, expected all zero",
               busy, done, result, rd_addr_out);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_start_ignored: busy=%b expected 0", busy);
    end
    start = 1'b0;
    @(negedge clk);
    rst      = 1'b1;
    last_res = 32'd0;
    last_rd  = 5'd0;
    do_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd18, 32'hFFFF_FFFE, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y;
    int          fl;
    for (int i = 0; i < 40; i++) begin
      o  = 3'($urandom_range(0, 7));
      x  = pick();
      y  = pick();
      fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 35)) : -1;
      do_op(o, x, y, 5'($urandom_range(1, 31)), ref_res(o, x, y), fl, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush_idle();
    test_flush_done();
    test_flush_restart();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
